// File: rtl/router_out_fifo_pkg.sv
// Shared types and constants for the per-destination router output FIFO.
// The byte width and default depth are fixed here. The storage word, the
// interface and the top all build on byte_t and fifo_word_t.
package router_out_fifo_pkg;

    localparam int FIFO_DEPTH  = 16;  // default entries (power of two, >= 4)
    localparam int FIFO_DWIDTH = 8;   // byte width of the data path
    localparam int PKT_CNT_W   = 6;   // width of the header length field

    typedef logic [FIFO_DWIDTH-1:0] byte_t;
    typedef logic [PKT_CNT_W-1:0]   pkt_cnt_t;

    // One storage entry: header tag above the byte.
    typedef struct packed {
        logic  hdr;
        byte_t data;
    } fifo_word_t;

    // A header byte carries the payload length in its upper six bits.
    // The packet also carries one parity byte, so the number of bytes still
    // owed after the header is length + 1.
    function automatic pkt_cnt_t hdr_to_cnt(input logic [PKT_CNT_W-1:0] len_field);
        return len_field + pkt_cnt_t'(1);
    endfunction

endpackage

// File: rtl/router_out_fifo_if.sv
// Bus bundle between the router core, the output FIFO and the destination.
//
// Handshake: nothing here waits on the other side, so there is no
// valid/ready stall.
//   - A write is taken on a clock edge when write_enb=1 and either full=0 or
//     a read is taken on the same edge. Otherwise the byte is dropped.
//   - A read is taken when read_enb=1 and empty=0. data_out then shows the
//     oldest byte after that edge.
//   - valid_out is simply !empty.
// pkt_cnt exposes the bytes still owed for the current packet. It is for
// observation only and does not take part in the handshake.
interface router_out_fifo_if;
    import router_out_fifo_pkg::*;

    logic     soft_reset;
    logic     write_enb;
    logic     lfd_state;
    byte_t    data_in;
    logic     read_enb;
    byte_t    data_out;
    logic     valid_out;
    logic     full;
    logic     empty;
    pkt_cnt_t pkt_cnt;

    // FIFO side
    modport slave (
        input  soft_reset,
        input  write_enb,
        input  lfd_state,
        input  data_in,
        input  read_enb,
        output data_out,
        output valid_out,
        output full,
        output empty,
        output pkt_cnt
    );

    // Router core plus destination side
    modport master (
        output soft_reset,
        output write_enb,
        output lfd_state,
        output data_in,
        output read_enb,
        input  data_out,
        input  valid_out,
        input  full,
        input  empty,
        input  pkt_cnt
    );

endinterface

// File: rtl/router_out_fifo_mem.sv
// Storage array for the output FIFO: DEPTH words of {hdr, data}.
// Writes are synchronous and reads are asynchronous.
// The data array has no reset. Stale header tags are masked by a per-entry
// live vector held in the top.
module router_out_fifo_mem
    import router_out_fifo_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  fifo_word_t    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output fifo_word_t    rdata_o
);

    fifo_word_t mem_q [DEPTH];

    // Store the word at the write address on an accepted write.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_out_fifo.sv
// Per-destination output buffer of the 1x3 router.
// It holds read/write pointers, flags, the packet byte counter and the
// registered data_out. Between packets the output returns to zero.
// soft_reset flushes a port whose destination has stopped reading.
module router_out_fifo
    import router_out_fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic               clock,
    input  logic               resetn,
    router_out_fifo_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;  // extra MSB separates full from empty
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0]    wp_q, wp_d;
    logic [PW-1:0]    rp_q, rp_d;
    logic [DEPTH-1:0] tag_live_q, tag_live_d;
    pkt_cnt_t         pkt_cnt_q, pkt_cnt_d;
    byte_t            data_out_q, data_out_d;

    logic       empty_w;
    logic       full_w;
    logic       rd_acc;
    logic       wr_acc;
    logic       mem_we;
    logic       rd_hdr;
    fifo_word_t wr_word;
    fifo_word_t rd_word;

    // Occupancy flags come straight from the pointers.
    assign empty_w = (wp_q == rp_q);
    assign full_w  = (wp_q[PW-1] != rp_q[PW-1]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);

    // A read frees a slot on the same edge, so a write at full is still taken
    // when a read accompanies it.
    assign rd_acc = bus.read_enb && !empty_w;
    assign wr_acc = bus.write_enb && (!full_w || rd_acc);
    assign mem_we = wr_acc && !bus.soft_reset;

    assign wr_word = '{hdr: bus.lfd_state, data: bus.data_in};

    router_out_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk_i   (clock),
        .we_i    (mem_we),
        .waddr_i (wp_q[AW-1:0]),
        .wdata_i (wr_word),
        .raddr_i (rp_q[AW-1:0]),
        .rdata_o (rd_word)
    );

    // The stored tag counts only if the entry was written since the last
    // reset or flush.
    assign rd_hdr = rd_word.hdr && tag_live_q[rp_q[AW-1:0]];

    // Next-state: pointers, tag-live vector, packet counter and output byte.
    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        tag_live_d = tag_live_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;

        if (bus.soft_reset) begin
            wp_d       = '0;
            rp_d       = '0;
            tag_live_d = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
        end else begin
            if (rd_acc) begin
                rp_d                         = rp_q + PTR_ONE;
                tag_live_d[rp_q[AW-1:0]]     = 1'b0;
                data_out_d                   = rd_word.data;
                if (rd_hdr) begin
                    pkt_cnt_d = hdr_to_cnt(rd_word.data[FIFO_DWIDTH-1:2]);
                end else if (pkt_cnt_q != '0) begin
                    pkt_cnt_d = pkt_cnt_q - pkt_cnt_t'(1);
                end
            end else if (pkt_cnt_q == '0) begin
                // Idle between packets: drive zero onto the destination bus.
                data_out_d = '0;
            end

            if (wr_acc) begin
                wp_d                     = wp_q + PTR_ONE;
                tag_live_d[wp_q[AW-1:0]] = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wp_q       <= '0;
            rp_q       <= '0;
            tag_live_q <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            tag_live_q <= tag_live_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = !empty_w;
    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_router_out_fifo.sv
// Directed bench for router_out_fifo.
// A table of per-cycle vectors covers packets, the idle zeroing, the hold
// behaviour and soft reset. Hand-written sequences cover full/overflow,
// read+write at full, pointer wrap and asynchronous reset.
module tb_router_out_fifo;
  import router_out_fifo_pkg::*;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  router_out_fifo_if bus ();

  router_out_fifo #(.DEPTH(16)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       srst;
    logic       we;
    logic       lfd;
    logic [7:0] din;
    logic       re;
    logic [7:0] e_dout;
    logic       e_valid;
    logic       e_full;
    logic       e_empty;
    logic [5:0] e_pkt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic srst, input logic we, input logic lfd,
                              input logic [7:0] din, input logic re,
                              input logic [7:0] e_dout, input logic e_valid,
                              input logic e_full, input logic e_empty,
                              input logic [5:0] e_pkt);
    vec_t v;
    v.srst = srst; v.we = we; v.lfd = lfd; v.din = din; v.re = re;
    v.e_dout = e_dout; v.e_valid = e_valid; v.e_full = e_full;
    v.e_empty = e_empty; v.e_pkt = e_pkt;
    vecs.push_back(v);
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic srst, input logic we, input logic lfd,
                       input logic [7:0] din, input logic re);
    bus.soft_reset = srst;
    bus.write_enb  = we;
    bus.lfd_state  = lfd;
    bus.data_in    = din;
    bus.read_enb   = re;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] e;
    logic [7:0] prev_dout;
    logic [7:0] din;
    logic       is_hdr;

    // Per-cycle table: srst we lfd din re | dout valid full empty pkt
    add(0,1,1,8'h0C,0, 8'h00,1,0,0,0);  // header, length 3
    add(0,1,0,8'hA1,0, 8'h00,1,0,0,0);
    add(0,1,0,8'hA2,0, 8'h00,1,0,0,0);
    add(0,1,0,8'hA3,0, 8'h00,1,0,0,0);
    add(0,1,0,8'h5E,0, 8'h00,1,0,0,0);  // parity
    add(0,0,0,8'h00,1, 8'h0C,1,0,0,4);
    add(0,0,0,8'h00,1, 8'hA1,1,0,0,3);
    add(0,0,0,8'h00,1, 8'hA2,1,0,0,2);
    add(0,0,0,8'h00,1, 8'hA3,1,0,0,1);
    add(0,0,0,8'h00,1, 8'h5E,0,0,1,0);  // last byte, valid falls
    add(0,0,0,8'h00,1, 8'h00,0,0,1,0);  // read at empty rejected, output zero
    add(0,1,0,8'h33,1, 8'h00,1,0,0,0);  // write+read at empty: write only
    add(0,0,0,8'h00,1, 8'h33,0,0,1,0);  // untagged read, counter stays 0
    add(0,0,0,8'h00,0, 8'h00,0,0,1,0);
    add(0,1,1,8'h00,0, 8'h00,1,0,0,0);  // header length 0
    add(0,1,0,8'h77,0, 8'h00,1,0,0,0);
    add(0,0,0,8'h00,1, 8'h00,1,0,0,1);
    add(0,0,0,8'h00,1, 8'h77,0,0,1,0);
    add(0,0,0,8'h00,0, 8'h00,0,0,1,0);
    add(0,1,1,8'h08,0, 8'h00,1,0,0,0);  // header length 2
    add(0,1,0,8'h11,0, 8'h00,1,0,0,0);
    add(0,0,0,8'h00,1, 8'h08,1,0,0,3);
    add(0,0,0,8'h00,0, 8'h08,1,0,0,3);  // mid-packet: hold
    add(0,0,0,8'h00,1, 8'h11,0,0,1,2);
    add(0,0,0,8'h00,0, 8'h11,0,0,1,2);  // still owed bytes: hold
    add(0,1,1,8'h44,0, 8'h11,1,0,0,2);  // store 5 bytes
    add(0,1,0,8'h45,0, 8'h11,1,0,0,2);
    add(0,1,0,8'h46,0, 8'h11,1,0,0,2);
    add(0,1,0,8'h47,0, 8'h11,1,0,0,2);
    add(0,1,0,8'h48,0, 8'h11,1,0,0,2);
    add(1,1,0,8'h99,0, 8'h00,0,0,1,0);  // soft reset drops the write
    add(0,0,0,8'h00,0, 8'h00,0,0,1,0);

    // Reset state
    drive(0,0,0,8'h00,0);
    resetn = 1'b0;
    repeat (2) tick();
    chk("rst dout",  32'(bus.data_out),  32'h00);
    chk("rst valid", 32'(bus.valid_out), 32'h0);
    chk("rst full",  32'(bus.full),      32'h0);
    chk("rst empty", 32'(bus.empty),     32'h1);
    chk("rst pkt",   32'(bus.pkt_cnt),   32'h0);
    @(negedge clock);
    resetn = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].srst, vecs[i].we, vecs[i].lfd, vecs[i].din, vecs[i].re);
      tick();
      chk($sformatf("vec%0d dout", i),  32'(bus.data_out),  32'(vecs[i].e_dout));
      chk($sformatf("vec%0d valid", i), 32'(bus.valid_out), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d full", i),  32'(bus.full),      32'(vecs[i].e_full));
      chk($sformatf("vec%0d empty", i), 32'(bus.empty),     32'(vecs[i].e_empty));
      chk($sformatf("vec%0d pkt", i),   32'(bus.pkt_cnt),   32'(vecs[i].e_pkt));
    end

    // Fill to full, then overflow
    for (int i = 0; i < 16; i++) begin
      din = 8'h10 + 8'(i);
      drive(0,1,0,din,0);
      exp_q.push_back(din);
      tick();
      chk($sformatf("fill%0d full", i), 32'(bus.full), (i == 15) ? 32'h1 : 32'h0);
    end
    drive(0,1,0,8'hFF,0);
    tick();
    chk("ovf full",  32'(bus.full),     32'h1);
    chk("ovf dout",  32'(bus.data_out), 32'h00);

    // Read+write at full: oldest byte out, new byte goes to the back
    drive(0,1,0,8'hAB,1);
    exp_q.push_back(8'hAB);
    tick();
    e = exp_q.pop_front();
    chk("rw_full dout", 32'(bus.data_out), 32'(e));
    chk("rw_full full", 32'(bus.full),     32'h1);

    // Drain
    for (int i = 0; i < 16; i++) begin
      drive(0,0,0,8'h00,1);
      tick();
      e = exp_q.pop_front();
      chk($sformatf("drain%0d dout", i), 32'(bus.data_out), 32'(e));
      chk($sformatf("drain%0d full", i), 32'(bus.full),     32'h0);
    end
    chk("drain empty", 32'(bus.empty), 32'h1);
    drive(0,0,0,8'h00,0);
    tick();
    chk("drain idle dout", 32'(bus.data_out), 32'h00);

    // Wrap: 40 write/read pairs, eight 5-byte packets of header length 3
    prev_dout = 8'h00;
    for (int i = 0; i < 40; i++) begin
      is_hdr = ((i % 5) == 0);
      din    = is_hdr ? 8'h0C : (8'h40 + 8'(i));
      drive(0,1,is_hdr,din,0);
      tick();
      chk($sformatf("wrap%0d wr empty", i), 32'(bus.empty),    32'h0);
      chk($sformatf("wrap%0d wr dout", i),  32'(bus.data_out), is_hdr ? 32'h0 : 32'(prev_dout));
      drive(0,0,0,8'h00,1);
      tick();
      chk($sformatf("wrap%0d rd dout", i),  32'(bus.data_out), 32'(din));
      chk($sformatf("wrap%0d rd pkt", i),   32'(bus.pkt_cnt),  32'(4 - (i % 5)));
      chk($sformatf("wrap%0d rd empty", i), 32'(bus.empty),    32'h1);
      prev_dout = din;
    end

    // Asynchronous reset in the middle of a packet
    drive(0,1,1,8'h10,0);
    tick();
    drive(0,1,0,8'h22,0);
    tick();
    drive(0,0,0,8'h00,1);
    tick();
    chk("pre_arst dout", 32'(bus.data_out), 32'h10);
    chk("pre_arst pkt",  32'(bus.pkt_cnt),  32'h5);
    drive(0,0,0,8'h00,0);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst dout",  32'(bus.data_out),  32'h00);
    chk("arst empty", 32'(bus.empty),     32'h1);
    chk("arst valid", 32'(bus.valid_out), 32'h0);
    chk("arst full",  32'(bus.full),      32'h0);
    chk("arst pkt",   32'(bus.pkt_cnt),   32'h0);
    tick();
    @(negedge clock);
    resetn = 1'b1;
    tick();
    chk("post_arst empty", 32'(bus.empty),    32'h1);
    chk("post_arst dout",  32'(bus.data_out), 32'h00);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
